mem_responder: RTL and testbench

Memory-side responder for the core's load/store and fetch interface. Accepts one request at a time over a valid/ready handshake, services it from an internal word array after a programmable fixed latency, and returns the result over a valid/ready response channel. Sits opposite the fetch/memory stages of the pipeline, replacing the zero-latency memory model so the pipeline can be exercised against realistic wait states, sub-word accesses and access faults.

---
 rtl/mem_responder.sv | 149 ++++++++++++++
 tb/tb_mem_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-request memory responder: accepts one load/store, waits a fixed latency,
// then services it from an internal word array and returns a held response.
module mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word, lane_shift, ld_data, wr_word;
  logic             access_err, do_access, mem_we;

  // Offset is only meaningful once the range check has passed.
  assign offset     = addr_q - BASE_ADDR;
  assign idx        = offset[IDX_W+1:2];
  assign rd_word    = mem_q[idx];
  assign lane_shift = rd_word >> {addr_q[1:0], 3'b000};

  always_comb begin
    access_err = 1'b0;
    if (size_q == 2'b11) access_err = 1'b1;
    if (size_q == 2'b01 && addr_q[0]) access_err = 1'b1;
    if (size_q == 2'b10 && addr_q[1:0] != 2'b00) access_err = 1'b1;
    if (addr_q < BASE_ADDR || offset >= SPAN) access_err = 1'b1;
  end

  always_comb begin
    ld_data = '0;
    wr_word = rd_word;
    case (size_q)
      2'b00: begin
        ld_data[7:0] = lane_shift[7:0];
        wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        ld_data[15:0] = lane_shift[15:0];
        wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        ld_data = lane_shift;
        wr_word = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    size_d    = size_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    rsp_valid = 1'b0;
    do_access = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          write_d = req_write;
          size_d  = req_size;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          do_access = 1'b1;
          error_d   = access_err;
          rdata_d   = (access_err || write_q) ? 32'd0 : ld_data;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign rsp_rdata = rdata_q;
  assign rsp_error = error_q;
  // A store due on a reset edge is dropped along with the request.
  assign mem_we    = do_access && write_q && !access_err && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[idx] <= wr_word;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: latency, sub-word lanes, faults, backpressure, reset abort.
module tb_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_responder dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error)
  );

  // Issue one request from IDLE and collect its response (rsp_ready assumed 1).
  task automatic xact(input logic [31:0] a, input logic w, input logic [1:0] s,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    req_addr = a; req_write = w; req_size = s; req_wdata = wd; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_error;
    if (!rsp_valid) lat = -1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready_low: got %b expected 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
    checks++; if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error: got %b expected 0", rsp_error); end
    reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    xact(32'h0100_0010, 1'b1, 2'b10, 32'hDEAD_BEEF, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_store_lat: got %0d expected 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_store_err: got %b expected 0", er); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL word_store_rdata: got %h expected 0", rd); end
    xact(32'h0100_0010, 1'b0, 2'b10, 32'h0, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_load_lat: got %0d expected 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL word_load_err: got %b expected 0", er); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL word_load_rdata: got %h expected deadbeef", rd); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic er; int lat;
    xact(32'h0100_0011, 1'b1, 2'b00, 32'h1234_56AA, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL byte_store: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
    xact(32'h0100_0010, 1'b0, 2'b10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD_AAEF) begin errors++; $display("FAIL byte_merge_word: got %h expected deadaaef", rd); end
    xact(32'h0100_0012, 1'b0, 2'b01, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_DEAD || er !== 1'b0) begin errors++; $display("FAIL half_load_hi: got %h err=%b expected 0000dead err=0", rd, er); end
    xact(32'h0100_0010, 1'b0, 2'b01, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_AAEF) begin errors++; $display("FAIL half_load_lo: got %h expected 0000aaef", rd); end
    xact(32'h0100_0011, 1'b0, 2'b00, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_00AA || er !== 1'b0) begin errors++; $display("FAIL byte_load_1: got %h err=%b expected 000000aa err=0", rd, er); end
    xact(32'h0100_0013, 1'b0, 2'b00, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_00DE) begin errors++; $display("FAIL byte_load_3: got %h expected 000000de", rd); end
  endtask

  task automatic test_faults();
    logic [31:0] fa [7] = '{32'h0100_0002, 32'h0100_0013, 32'h00FF_FFFC, 32'h0100_1000,
                            32'h0100_0010, 32'h0000_0000, 32'h0100_0011};
    logic        fw [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  fs [7] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 7; i++) begin
      xact(fa[i], fw[i], fs[i], 32'h5555_5555, rd, er, lat);
      checks++;
      if (er !== 1'b1 || rd !== 32'd0 || lat !== 2) begin
        errors++;
        $display("FAIL fault_%0d addr=%h: got err=%b rdata=%h lat=%0d expected err=1 rdata=0 lat=2", i, fa[i], er, rd, lat);
      end
    end
    xact(32'h0100_0010, 1'b0, 2'b10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD_AAEF) begin errors++; $display("FAIL fault_mem_unchanged: got %h expected deadaaef", rd); end
    xact(32'h0100_0FFC, 1'b1, 2'b10, 32'hCAFE_F00D, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL top_word_store_err: got %b expected 0", er); end
    xact(32'h0100_0FFC, 1'b0, 2'b10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin errors++; $display("FAIL top_word_load: got %h err=%b expected cafef00d err=0", rd, er); end
    xact(32'h0100_0FFF, 1'b0, 2'b00, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0000_00CA || er !== 1'b0) begin errors++; $display("FAIL top_byte_load: got %h err=%b expected 000000ca err=0", rd, er); end
  endtask

  task automatic test_back_to_back();
    int lat;
    rsp_ready = 1'b0;
    req_addr = 32'h0100_0010; req_write = 1'b0; req_size = 2'b10; req_valid = 1'b1;
    @(posedge clock); #1;
    req_addr = 32'h0100_0FFC;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_AAEF) begin errors++; $display("FAIL bp_first_rsp: got valid=%b rdata=%h expected valid=1 rdata=deadaaef", rsp_valid, rsp_rdata); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_AAEF || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b rdata=%h req_ready=%b expected 1 deadaaef 0", i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake: got req_ready=%b rsp_valid=%b expected 1 0", req_ready, rsp_valid); end
    @(posedge clock); #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got req_ready=%b expected 0", req_ready); end
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    checks++; if (lat !== 2 || rsp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL bp_second_rsp: got lat=%0d rdata=%h expected 2 cafef00d", lat, rsp_rdata); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    xact(32'h0100_0020, 1'b1, 2'b10, 32'h0, rd, er, lat);
    req_addr = 32'h0100_0020; req_write = 1'b1; req_size = 2'b10; req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_abort: got rsp_valid=%b req_ready=%b expected 0 0", rsp_valid, req_ready); end
    reset = 1'b0;
    #1;
    xact(32'h0100_0020, 1'b0, 2'b10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin errors++; $display("FAIL mid_reset_dropped: got rdata=%h err=%b lat=%0d expected 0 0 2", rd, er, lat); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
